puf_response_sipo: RTL and testbench

Parametrised serial-in/parallel-out collector for RO-PUF response bits. It is the successor to the fixed 256-bit enable-gated shift register.
- Accepts one response bit per valid/ready handshake.
- Counts bits and frames a complete WIDTH-bit word.
- Double-buffers it into a held output register with a valid/ack handshake, so the next response fills while the previous one is consumed.
- Sits between the RO comparator bit stream and the response/key post-processing logic.

---
 rtl/puf_pkg.sv | 7 +
 rtl/puf_response_sipo_if.sv | 15 +
 rtl/puf_shift_core.sv | 34 +++
 rtl/puf_response_sipo.sv | 61 ++++++
 tb/tb_puf_response_sipo.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and constants for the PUF response collector.
package puf_pkg;
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
    localparam int SHIFT_TO_MSB = 0;
    localparam int SHIFT_TO_LSB = 1;
    localparam int PUF_RESP_W = 256;
endpackage

// File: rtl/puf_response_sipo_if.sv
// puf_response_sipo_if: serial bit input and held parallel word output bundle.
interface puf_response_sipo_if #(parameter int WIDTH = puf_pkg::PUF_RESP_W);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic             clr;
    logic             s_in;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ack;
    logic [CNT_W-1:0] bit_cnt;
    logic             overflow;
    modport master (output clr, s_in, s_valid, p_ack, input s_ready, p_out, p_valid, bit_cnt, overflow);
    modport slave (input clr, s_in, s_valid, p_ack, output s_ready, p_out, p_valid, bit_cnt, overflow);
endinterface

// File: rtl/puf_shift_core.sv
// puf_shift_core: direction-selectable shift register with bit counter and last-bit flag.
module puf_shift_core
    import puf_pkg::*;
#(
    parameter int WIDTH = PUF_RESP_W,
    parameter int SHIFT_DIR = SHIFT_TO_MSB,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    input  logic             cnt_zero,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] sr_next,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             last
);
    assign sr_next = (SHIFT_DIR == SHIFT_TO_MSB) ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
    assign last = (bit_cnt == CNT_W'(WIDTH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr <= '0;
            bit_cnt <= '0;
        end else begin
            if (en) sr <= sr_next;
            bit_cnt <= cnt_zero ? '0 : en ? bit_cnt + 1'b1 : bit_cnt;
        end
    end
endmodule

// File: rtl/puf_response_sipo.sv
// puf_response_sipo: frames serial PUF bits into WIDTH-bit words and double-buffers
// them behind a valid/ack output register.
module puf_response_sipo
    import puf_pkg::*;
#(
    parameter int WIDTH = PUF_RESP_W,
    parameter int SHIFT_DIR = SHIFT_TO_MSB
) (
    input logic clk,
    input logic rst,
    puf_response_sipo_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    state_t           state;
    logic [WIDTH-1:0] sr, sr_next, p_out;
    logic [CNT_W-1:0] bit_cnt;
    logic             last, p_valid, overflow;
    logic             s_ready, accept, load_direct, hold_go, hold_rel;
    assign s_ready = (state == FILL);
    assign accept = bus.s_valid & s_ready;
    // A finished word bypasses HOLD whenever the output slot is free or being freed.
    assign load_direct = accept & last & (~p_valid | bus.p_ack);
    assign hold_go = accept & last & ~load_direct;
    assign hold_rel = (state == HOLD) & bus.p_ack;
    puf_shift_core #(.WIDTH(WIDTH), .SHIFT_DIR(SHIFT_DIR)) u_core (
        .clk(clk), .rst(rst), .clr(bus.clr), .en(accept), .din(bus.s_in),
        .cnt_zero(load_direct | hold_rel), .sr(sr), .sr_next(sr_next),
        .bit_cnt(bit_cnt), .last(last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            p_out <= '0;
            p_valid <= 1'b0;
            overflow <= 1'b0;
        end else if (bus.clr) begin
            state <= FILL;
            p_out <= '0;
            p_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.s_valid && !s_ready) overflow <= 1'b1;
            if (load_direct) begin
                p_out <= sr_next;
                p_valid <= 1'b1;
            end else if (hold_rel) begin
                p_out <= sr;
                p_valid <= 1'b1;
                state <= FILL;
            end else if (bus.p_ack) begin
                p_valid <= 1'b0;
            end
            if (hold_go) state <= HOLD;
        end
    end
    assign bus.s_ready = s_ready;
    assign bus.p_out = p_out;
    assign bus.p_valid = p_valid;
    assign bus.bit_cnt = bit_cnt;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_puf_response_sipo.sv
// tb_puf_response_sipo: directed checks of framing, bit order, back-pressure, clear and reset.
module tb_puf_response_sipo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    puf_response_sipo_if #(.WIDTH(8)) a ();
    puf_response_sipo_if #(.WIDTH(8)) b ();
    puf_response_sipo #(.WIDTH(8), .SHIFT_DIR(0)) dut0 (.clk(clk), .rst(rst), .bus(a));
    puf_response_sipo #(.WIDTH(8), .SHIFT_DIR(1)) dut1 (.clk(clk), .rst(rst), .bus(b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] v, input logic ack_last);
        for (int i = 0; i < 8; i++) begin
            a.s_in = v[7-i];
            a.s_valid = 1'b1;
            a.p_ack = ack_last && (i == 7);
            tick();
        end
        a.s_valid = 1'b0;
        a.p_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_cmp++; if (a.p_out !== 8'h00) begin n_err++; $display("FAIL reset_p_out got %h want 00", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b0) begin n_err++; $display("FAIL reset_p_valid got %b want 0", a.p_valid); end
        n_cmp++; if (a.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", a.s_ready); end
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL reset_bit_cnt got %0d want 0", a.bit_cnt); end
        n_cmp++; if (a.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", a.overflow); end
        n_cmp++; if (b.p_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_p_valid got %b want 0", b.p_valid); end
    endtask

    task automatic test_lsb_entry;
        logic [7:0] v = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            a.s_in = v[7-i];
            a.s_valid = 1'b1;
            tick();
            if (i < 7) begin
                n_cmp++; if (a.bit_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL t2_bit_cnt got %0d want %0d", a.bit_cnt, i + 1); end
            end
        end
        a.s_valid = 1'b0;
        n_cmp++; if (a.p_out !== 8'hAA) begin n_err++; $display("FAIL t2_p_out got %h want aa", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b1) begin n_err++; $display("FAIL t2_p_valid got %b want 1", a.p_valid); end
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL t2_bit_cnt_end got %0d want 0", a.bit_cnt); end
    endtask

    task automatic test_msb_entry_gaps;
        logic [7:0] v = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            b.s_in = v[7-i];
            b.s_valid = 1'b1;
            tick();
            if (i == 2 || i == 5) begin
                b.s_valid = 1'b0;
                b.s_in = 1'b1;
                repeat (2) tick();
                n_cmp++; if (b.bit_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL t3_gap_cnt got %0d want %0d", b.bit_cnt, i + 1); end
            end
        end
        b.s_valid = 1'b0;
        n_cmp++; if (b.p_out !== 8'h55) begin n_err++; $display("FAIL t3_p_out got %h want 55", b.p_out); end
        n_cmp++; if (b.p_valid !== 1'b1) begin n_err++; $display("FAIL t3_p_valid got %b want 1", b.p_valid); end
    endtask

    task automatic test_back_pressure;
        send_a(8'hF0, 1'b0);
        n_cmp++; if (a.s_ready !== 1'b0) begin n_err++; $display("FAIL t4_hold_s_ready got %b want 0", a.s_ready); end
        n_cmp++; if (a.bit_cnt !== 4'd8) begin n_err++; $display("FAIL t4_hold_bit_cnt got %0d want 8", a.bit_cnt); end
        n_cmp++; if (a.p_out !== 8'hAA) begin n_err++; $display("FAIL t4_hold_p_out got %h want aa", a.p_out); end
        n_cmp++; if (a.overflow !== 1'b0) begin n_err++; $display("FAIL t4_pre_overflow got %b want 0", a.overflow); end
        a.s_in = 1'b1;
        a.s_valid = 1'b1;
        tick();
        a.s_valid = 1'b0;
        n_cmp++; if (a.overflow !== 1'b1) begin n_err++; $display("FAIL t4_overflow got %b want 1", a.overflow); end
        n_cmp++; if (a.bit_cnt !== 4'd8) begin n_err++; $display("FAIL t4_drop_cnt got %0d want 8", a.bit_cnt); end
        a.p_ack = 1'b1;
        tick();
        a.p_ack = 1'b0;
        n_cmp++; if (a.p_out !== 8'hF0) begin n_err++; $display("FAIL t4_rel_p_out got %h want f0", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b1) begin n_err++; $display("FAIL t4_rel_p_valid got %b want 1", a.p_valid); end
        n_cmp++; if (a.s_ready !== 1'b1) begin n_err++; $display("FAIL t4_rel_s_ready got %b want 1", a.s_ready); end
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL t4_rel_bit_cnt got %0d want 0", a.bit_cnt); end
    endtask

    task automatic test_simultaneous;
        a.p_ack = 1'b1;
        tick();
        a.p_ack = 1'b0;
        send_a(8'hAA, 1'b0);
        n_cmp++; if (a.p_out !== 8'hAA) begin n_err++; $display("FAIL t5_pre_p_out got %h want aa", a.p_out); end
        send_a(8'h0F, 1'b1);
        n_cmp++; if (a.p_out !== 8'h0F) begin n_err++; $display("FAIL t5_p_out got %h want 0f", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b1) begin n_err++; $display("FAIL t5_p_valid got %b want 1", a.p_valid); end
        n_cmp++; if (a.s_ready !== 1'b1) begin n_err++; $display("FAIL t5_no_hold got %b want 1", a.s_ready); end
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL t5_bit_cnt got %0d want 0", a.bit_cnt); end
        a.p_ack = 1'b1;
        tick();
        a.p_ack = 1'b0;
        n_cmp++; if (a.p_valid !== 1'b0) begin n_err++; $display("FAIL t5_ack_p_valid got %b want 0", a.p_valid); end
        n_cmp++; if (a.p_out !== 8'h0F) begin n_err++; $display("FAIL t5_ack_p_out got %h want 0f", a.p_out); end
    endtask

    task automatic test_clear_reset;
        a.s_valid = 1'b1;
        a.s_in = 1'b1;
        repeat (3) tick();
        a.s_valid = 1'b0;
        n_cmp++; if (a.bit_cnt !== 4'd3) begin n_err++; $display("FAIL t6_pre_cnt got %0d want 3", a.bit_cnt); end
        a.clr = 1'b1;
        a.s_valid = 1'b1;
        tick();
        a.clr = 1'b0;
        a.s_valid = 1'b0;
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL t6_clr_cnt got %0d want 0", a.bit_cnt); end
        n_cmp++; if (a.p_valid !== 1'b0) begin n_err++; $display("FAIL t6_clr_p_valid got %b want 0", a.p_valid); end
        n_cmp++; if (a.overflow !== 1'b0) begin n_err++; $display("FAIL t6_clr_overflow got %b want 0", a.overflow); end
        send_a(8'hAA, 1'b0);
        send_a(8'hF0, 1'b0);
        n_cmp++; if (a.s_ready !== 1'b0) begin n_err++; $display("FAIL t6_in_hold got %b want 0", a.s_ready); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (a.p_out !== 8'h00) begin n_err++; $display("FAIL t6_rst_p_out got %h want 00", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b0) begin n_err++; $display("FAIL t6_rst_p_valid got %b want 0", a.p_valid); end
        n_cmp++; if (a.bit_cnt !== 4'd0) begin n_err++; $display("FAIL t6_rst_bit_cnt got %0d want 0", a.bit_cnt); end
        n_cmp++; if (a.s_ready !== 1'b1) begin n_err++; $display("FAIL t6_rst_s_ready got %b want 1", a.s_ready); end
        #1 rst = 1'b0;
        tick();
        send_a(8'hC3, 1'b0);
        n_cmp++; if (a.p_out !== 8'hC3) begin n_err++; $display("FAIL t6_fresh_p_out got %h want c3", a.p_out); end
        n_cmp++; if (a.p_valid !== 1'b1) begin n_err++; $display("FAIL t6_fresh_p_valid got %b want 1", a.p_valid); end
    endtask

    initial begin
        a.clr = 1'b0; a.s_in = 1'b0; a.s_valid = 1'b0; a.p_ack = 1'b0;
        b.clr = 1'b0; b.s_in = 1'b0; b.s_valid = 1'b0; b.p_ack = 1'b0;
        test_reset();
        test_lsb_entry();
        test_msb_entry_gaps();
        test_back_pressure();
        test_simultaneous();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
